hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/mips_pkg.sv | 15 +
 rtl/sat_counter.sv | 24 ++
 rtl/hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard control slice.
// Holds the hazard FSM state encoding and the NOP instruction word that a
// flushed IF_ID register is cleared to.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk   - clock, counts on rising edge
//   rst_n - asynchronous active-low reset, clears the count
//   en    - increment enable
//   count - current value; holds at all ones once reached
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and
// memory-not-ready freeze, with stall / flush statistics.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   id_rs, id_rt           - source registers of the IF_ID instruction
//   ex_memread, ex_rt      - ID_EX instruction is a load / its destination
//   branch_taken           - one-cycle pulse, branch resolved taken
//   mem_ready              - memories ready; low freezes the whole pipe
//   pc_we, ifid_we         - PC and IF_ID write enables
//   ifid_flush             - clear IF_ID to NOP at next edge
//   idex_bubble            - insert NOP into ID_EX at next edge
//   state                  - current FSM state encoding
//   stall_cnt, flush_cnt   - saturating statistics counters
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] FC_FULL = 2'(FLUSH_CYCLES);
  localparam logic [1:0] FC_M1   = 2'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] rem_q, rem_d;
  logic       pend_q, pend_d;
  // Set when a WAIT exit starts a brand-new redirect, so its first flush
  // cycle is counted; a resumed (interrupted) flush is not counted twice.
  logic       fresh_q, fresh_d;

  logic load_use;
  logic pc_we_c, ifid_we_c, ifid_flush_c, idex_bubble_c;
  logic flush_inc;

  assign load_use = ex_memread && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      rem_q   <= '0;
      pend_q  <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
      fresh_q <= fresh_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    pend_d        = pend_q;
    fresh_d       = fresh_q;
    pc_we_c       = mem_ready;
    ifid_we_c     = mem_ready;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    flush_inc     = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (!mem_ready) begin
          state_d = ST_WAIT;
          pend_d  = pend_q | branch_taken;
        end else if (branch_taken) begin
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          flush_inc     = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            rem_d   = FC_M1;
          end else begin
            rem_d = '0;
          end
        end else if (load_use) begin
          pc_we_c       = 1'b0;
          ifid_we_c     = 1'b0;
          idex_bubble_c = 1'b1;
        end
      end

      ST_FLUSH: begin
        if (!mem_ready) begin
          state_d = ST_WAIT;
          pend_d  = pend_q | branch_taken;
        end else begin
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          flush_inc     = fresh_q;
          fresh_d       = 1'b0;
          if (rem_q <= 2'd1) begin
            rem_d   = '0;
            state_d = ST_RUN;
          end else begin
            rem_d = rem_q - 2'd1;
          end
        end
      end

      ST_WAIT: begin
        // Exit cycle stays frozen too; the redirect starts next cycle.
        pc_we_c   = 1'b0;
        ifid_we_c = 1'b0;
        if (!mem_ready) begin
          pend_d = pend_q | branch_taken;
        end else begin
          pend_d = 1'b0;
          if (pend_q || branch_taken) begin
            state_d = ST_FLUSH;
            rem_d   = FC_FULL;
            fresh_d = 1'b1;
          end else if (rem_q != '0) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      default: begin
        state_d = ST_RUN;
        rem_d   = '0;
        pend_d  = 1'b0;
        fresh_d = 1'b0;
      end
    endcase
  end

  // Reset forces the free-running pass-through outputs regardless of inputs.
  assign pc_we       = rst_n ? pc_we_c       : 1'b1;
  assign ifid_we     = rst_n ? ifid_we_c     : 1'b1;
  assign ifid_flush  = rst_n ? ifid_flush_c  : 1'b0;
  assign idex_bubble = rst_n ? idex_bubble_c : 1'b0;
  assign state       = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~pc_we),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver issues directed vectors and
// queues hand-computed expected outputs; a monitor pops and compares each
// cycle at the falling edge. Two instances: default parameters, and
// FLUSH_CYCLES=1 with 2-bit counters to reach saturation.
module tb_hazard_ctrl;
  import mips_pkg::*;

  typedef struct packed {
    logic [3:0]  en;   // {pc_we, ifid_we, ifid_flush, idex_bubble}
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    obs_t        e;
    int unsigned tag;
  } item_t;

  item_t q0[$];
  item_t q1[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned vec   = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic       a_mr = 1'b1, a_bt = 1'b0, a_em = 1'b0;
  logic [4:0] a_ert = 5'd0, a_ids = 5'd1, a_idt = 5'd2;
  logic       b_mr = 1'b1, b_bt = 1'b0, b_em = 1'b0;
  logic [4:0] b_ert = 5'd0, b_ids = 5'd1, b_idt = 5'd2;

  logic        a_pc, a_ifid, a_fl, a_bub;
  logic [1:0]  a_st;
  logic [15:0] a_sc, a_fc;
  logic        b_pc, b_ifid, b_fl, b_bub;
  logic [1:0]  b_st;
  logic [1:0]  b_sc, b_fc;

  obs_t obs0, obs1;
  assign obs0 = {a_pc, a_ifid, a_fl, a_bub, a_st, a_sc, a_fc};
  assign obs1 = {b_pc, b_ifid, b_fl, b_bub, b_st, 14'd0, b_sc, 14'd0, b_fc};

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .id_rs(a_ids), .id_rt(a_idt),
    .ex_memread(a_em), .ex_rt(a_ert), .branch_taken(a_bt), .mem_ready(a_mr),
    .pc_we(a_pc), .ifid_we(a_ifid), .ifid_flush(a_fl), .idex_bubble(a_bub),
    .state(a_st), .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_rs(b_ids), .id_rt(b_idt),
    .ex_memread(b_em), .ex_rt(b_ert), .branch_taken(b_bt), .mem_ready(b_mr),
    .pc_we(b_pc), .ifid_we(b_ifid), .ifid_flush(b_fl), .idex_bubble(b_bub),
    .state(b_st), .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  task automatic drive(input int d, input logic rn, mr, bt, em,
                       input logic [4:0] ert, ids, idt,
                       input logic [3:0] en, input logic [1:0] st,
                       input int sc, input int fc);
    item_t it;
    @(posedge clk);
    #1;
    rst_n = rn;
    it.e   = {en, st, 16'(sc), 16'(fc)};
    it.tag = vec;
    vec++;
    if (d == 0) begin
      a_mr = mr; a_bt = bt; a_em = em; a_ert = ert; a_ids = ids; a_idt = idt;
      q0.push_back(it);
    end else begin
      b_mr = mr; b_bt = bt; b_em = em; b_ert = ert; b_ids = ids; b_idt = idt;
      q1.push_back(it);
    end
  endtask

  task automatic check(input int d, input item_t it, input obs_t got);
    n_cmp++;
    if (got !== it.e) begin
      n_bad++;
      $display("FAIL d%0d_v%0d actual: en=%b st=%0d stall=%0d flush=%0d required: en=%b st=%0d stall=%0d flush=%0d",
               d, it.tag, got.en, got.st, got.sc, got.fc,
               it.e.en, it.e.st, it.e.sc, it.e.fc);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) check(0, q0.pop_front(), obs0);
    if (q1.size() > 0) check(1, q1.pop_front(), obs1);
  end

  initial begin
    // Default instance, FLUSH_CYCLES=2
    drive(0, 0, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b1100, 0, 0, 0);  // in reset
    drive(0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b1100, 0, 0, 0);
    drive(0, 1, 1, 0, 1, 5'd8, 5'd8, 5'd2, 4'b0001, 0, 0, 0);  // load-use rs
    drive(0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b1100, 0, 1, 0);
    drive(0, 1, 1, 0, 1, 5'd0, 5'd0, 5'd0, 4'b1100, 0, 1, 0);  // $zero no stall
    drive(0, 1, 1, 0, 1, 5'd9, 5'd3, 5'd9, 4'b0001, 0, 1, 0);  // load-use rt
    drive(0, 1, 1, 0, 0, 5'd9, 5'd9, 5'd9, 4'b1100, 0, 2, 0);  // not a load
    drive(0, 1, 1, 1, 0, 5'd0, 5'd1, 5'd2, 4'b1111, 0, 2, 0);  // branch
    drive(0, 1, 1, 0, 1, 5'd8, 5'd8, 5'd2, 4'b1111, 1, 2, 1);  // flush ignores load-use
    drive(0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b1100, 0, 2, 1);
    drive(0, 1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 4'b0000, 0, 2, 1);  // freeze
    drive(0, 1, 0, 1, 0, 5'd0, 5'd1, 5'd2, 4'b0000, 2, 3, 1);  // branch in wait
    drive(0, 1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 4'b0000, 2, 4, 1);
    drive(0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b0000, 2, 5, 1);  // wait exit
    drive(0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b1111, 1, 6, 1);
    drive(0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b1111, 1, 6, 2);
    drive(0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b1100, 0, 6, 2);
    drive(0, 1, 0, 0, 1, 5'd8, 5'd8, 5'd2, 4'b0000, 0, 6, 2);  // freeze beats load-use
    drive(0, 1, 1, 0, 1, 5'd8, 5'd8, 5'd2, 4'b0000, 2, 7, 2);
    drive(0, 1, 1, 0, 1, 5'd8, 5'd8, 5'd2, 4'b0001, 0, 8, 2);  // bubble after wait
    drive(0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b1100, 0, 9, 2);
    drive(0, 1, 1, 1, 0, 5'd0, 5'd1, 5'd2, 4'b1111, 0, 9, 2);  // branch
    drive(0, 1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 4'b0000, 1, 9, 3);  // freeze mid-flush
    drive(0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b0000, 2, 10, 3);
    drive(0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b1111, 1, 11, 3); // resumed, not recounted
    drive(0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b1100, 0, 11, 3);
    drive(0, 1, 1, 1, 1, 5'd8, 5'd8, 5'd2, 4'b1111, 0, 11, 3); // branch beats load-use
    drive(0, 0, 0, 1, 1, 5'd8, 5'd8, 5'd2, 4'b1100, 0, 0, 0);  // reset during flush
    drive(0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b1100, 0, 0, 0);  // no residual flush
    drive(0, 1, 0, 1, 0, 5'd0, 5'd1, 5'd2, 4'b0000, 0, 0, 0);  // freeze beats branch
    drive(0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b0000, 2, 1, 0);
    drive(0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b1111, 1, 2, 0);
    drive(0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b1111, 1, 2, 1);
    drive(0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b1100, 0, 2, 1);
    // Second instance, FLUSH_CYCLES=1, 2-bit counters
    drive(1, 1, 1, 1, 0, 5'd0, 5'd1, 5'd2, 4'b1111, 0, 0, 0);
    drive(1, 1, 1, 1, 0, 5'd0, 5'd1, 5'd2, 4'b1111, 0, 0, 1);
    drive(1, 1, 1, 1, 0, 5'd0, 5'd1, 5'd2, 4'b1111, 0, 0, 2);
    drive(1, 1, 1, 1, 0, 5'd0, 5'd1, 5'd2, 4'b1111, 0, 0, 3);
    drive(1, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b1100, 0, 0, 3);  // flush_cnt saturated
    drive(1, 1, 1, 0, 1, 5'd8, 5'd8, 5'd2, 4'b0001, 0, 0, 3);
    drive(1, 1, 1, 0, 1, 5'd8, 5'd8, 5'd2, 4'b0001, 0, 1, 3);
    drive(1, 1, 1, 0, 1, 5'd8, 5'd8, 5'd2, 4'b0001, 0, 2, 3);
    drive(1, 1, 1, 0, 1, 5'd8, 5'd8, 5'd2, 4'b0001, 0, 3, 3);
    drive(1, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b1100, 0, 3, 3);  // stall_cnt saturated
    drive(1, 1, 0, 1, 0, 5'd0, 5'd1, 5'd2, 4'b0000, 0, 3, 3);
    drive(1, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b0000, 2, 3, 3);
    drive(1, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b1111, 1, 3, 3);
    drive(1, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 4'b1100, 0, 3, 3);

    for (int i = 0; i < 20 && (q0.size() + q1.size()) > 0; i++) @(posedge clk);
    if ((q0.size() + q1.size()) > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected items still queued, required 0",
               q0.size() + q1.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
